muxed_display_ctrl: RTL
=======================

Name: muxed_display_ctrl

Overview:
- Parametrised successor to the current fixed 4-digit muxed seven-segment peripheral.
- Generalised to 1–8 digits with selectable pin polarity.
- Adds register-controlled brightness PWM, per-digit blanking, decimal points, blink and an inter-digit ghost-suppression gap.
- Sits as user logic behind the PLB slave IPIF in the display pcore, on the SPLB_Clk domain; drives the board anodes/segments directly.

Parameters:
- C_NUM_DIGITS, 4, number of multiplexed digits; legal range 1–8.
- C_REFRESH_DIV, 66667, SPLB_Clk cycles per digit slot (1 ms at 15000 ps); minimum 20.
- C_BLINK_SCANS, 256, full scans per blink half-period; power of two.
- C_SEG_ACTIVE_LOW, 1, 1 means a lit segment drives 0.
- C_AN_ACTIVE_LOW, 1, 1 means a selected anode drives 0.
- C_SLV_DWIDTH, 32, IPIF data width; fixed at 32.

Ports:
- SPLB_Clk  in  1  sole clock.
- SPLB_Rst  in  1  synchronous, active-high reset.
- Bus2IP_Data  in  [0:31]  write data; bit 31 = LSB.
- Bus2IP_BE  in  [0:3]  byte enables; BE[3] covers bits 24–31.
- Bus2IP_WrCE  in  [0:3]  one-hot write chip enables, regs 0–3.
- Bus2IP_RdCE  in  [0:3]  one-hot read chip enables, regs 0–3.
- IP2Bus_Data  out  [0:31]  read data.
- IP2Bus_WrAck  out  1  write acknowledge.
- IP2Bus_RdAck  out  1  read acknowledge.
- IP2Bus_Error  out  1  tied 0.
- segments  out  [0:7]  a,b,c,d,e,f,g,dp in index order 0..7; registered.
- anodes  out  [0:C_NUM_DIGITS-1]  index k selects digit k; registered.

Behaviour:
- Registers (numeric bit n = Bus2IP_Data[31-n]):
  - REG0 DIGITS: digit k hex value = bits [4k+3:4k].
  - REG1 CTRL: bit0 enable; bits[7:4] brightness B; bit8 ghost-gap enable.
  - REG2 MASK: bits[7:0] blank mask; bits[15:8] dp mask; bits[23:16] blink mask.
  - REG3 STATUS: read-only. bits[2:0] current digit index; bit3 blink phase; writes ignored.
- Writes: byte-lane granular per BE. Bits for digits at or above C_NUM_DIGITS read back 0.
- Acks: IP2Bus_WrAck = OR(WrCE); IP2Bus_RdAck = OR(RdCE); both combinational, same cycle as CE, single-beat. IP2Bus_Data = selected register when any RdCE is set, else 0.
- Reset: all registers 0, prescaler 0, digit index 0, PWM counter 0, blink counter 0, blink phase 0. Outputs take the inactive level on the cycle after SPLB_Rst is sampled high: every anode and every segment off, polarity-adjusted.
- Disabled (enable=0): prescaler, digit index, PWM and blink counters are held at 0; outputs inactive one cycle after the write.
- Scan:
  - Prescaler counts 0..C_REFRESH_DIV-1. The wrap cycle is slot_tick.
  - On slot_tick the digit index increments, wrapping from C_NUM_DIGITS-1 to 0. A wrap is scan_done.
  - C_NUM_DIGITS=1: the index stays 0 and every slot_tick is scan_done.
- Blink: counter increments on scan_done; blink phase toggles when it wraps at C_BLINK_SCANS.
- PWM: 4-bit free-running counter P, increments every enabled cycle. Digit is lit when P <= B, giving duty (B+1)/16; B=15 is always lit.
- Ghost gap: when enabled, prescaler values 0 and 1 of each slot force all anodes inactive.
- Anode k active only when all hold: k == index, enable, not blank[k], not (blink[k] and blink phase), PWM lit, not in gap.
- Segments: hex-decode of the current digit (standard 0–F glyphs, A b C d E F), dp = dp mask[index], polarity-applied. Segments still drive the glyph when the anode is suppressed, except under reset or disable.
- Output timing: one-cycle registered latency from internal state to pins. A register write is visible on the pins 2 cycles after its WrCE cycle.
- Simultaneous events:
  - Write coincident with slot_tick: the new index uses the new register value.
  - Reset overrides any write in the same cycle.
  - A write to CTRL that changes B takes effect mid-slot with no counter reset.

Decomposition:
- Package muxed_display_pkg:
  - register index constants;
  - CTRL/MASK bit-position constants;
  - 16-entry hex-to-segment constant table (active-high a..g);
  - function apply_polarity.
- One sub-module: seg_hex_decoder (4-bit in, 7-bit active-high out, combinational).
- Counters, registers and output stage stay in the top level.

Test Plan (C_REFRESH_DIV=20, C_BLINK_SCANS=2, C_NUM_DIGITS=4, active-low; the second case uses C_NUM_DIGITS=8):
- Reset then idle: outputs idle-high. Write CTRL=0x0F1 (B=15, enable=1), DIGITS=0x1234 -> anodes cycle 1110,1101,1011,0111 every 20 cycles. Segments for digit0 = "4" = 10011001 (dp off).
- C_NUM_DIGITS=8, DIGITS=0x89ABCDEF -> each digit shows its glyph in turn; index wraps 7->0. With C_NUM_DIGITS=4, readback of DIGITS bits above 15 returns 0.
- B=3 -> within a slot the anode is active for 4 of every 16 cycles. Ghost gap on -> first 2 cycles of each slot all anodes 1111.
- MASK blank=0x2, dp=0x1, blink=0x4 -> digit1 never lit; digit0 dp segment=0; digit2 lit only on alternate scan pairs (STATUS bit3 = 0).
- Write with BE=0001 to DIGITS=0xFFFFFFFF over 0x1234 -> readback 0x12FF. WrAck/RdAck high exactly in CE cycles; Error always 0.
- Assert SPLB_Rst mid-slot (index=2) for one cycle -> next cycle all outputs inactive, registers read 0, STATUS=0.

Source files
------------

// File: rtl/muxed_display_pkg.sv
// Shared constants for the muxed seven-segment display controller:
// register map, field positions, hex glyph table and pin polarity helper.
package muxed_display_pkg;

  localparam int REG_DIGITS = 0;
  localparam int REG_CTRL   = 1;
  localparam int REG_MASK   = 2;
  localparam int REG_STATUS = 3;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_BRIGHT_LSB = 4;
  localparam int CTRL_GAP        = 8;
  // Only enable, brightness and ghost-gap bits are stored.
  localparam logic [31:0] CTRL_WMASK = 32'h0000_01F1;

  localparam int MASK_BLANK_LSB = 0;
  localparam int MASK_DP_LSB    = 8;
  localparam int MASK_BLINK_LSB = 16;

  // Active-high glyphs, bit i = segment i (a = bit0 .. g = bit6); entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] apply_polarity(input logic [7:0] v, input bit activeLow);
    return activeLow ? ~v : v;
  endfunction

endpackage

// File: rtl/muxed_display_ctrl_hexdec.sv
// Combinational 4-bit hex to active-high a..g segment decoder.
module seg_hex_decoder
  import muxed_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/muxed_display_ctrl.sv
// Multiplexed seven-segment controller behind the PLB IPIF: register file,
// scan/PWM/blink counters and a registered pin stage.
module muxed_display_ctrl
  import muxed_display_pkg::*;
#(
  parameter int C_NUM_DIGITS     = 4,
  parameter int C_REFRESH_DIV    = 66667,
  parameter int C_BLINK_SCANS    = 256,
  parameter int C_SEG_ACTIVE_LOW = 1,
  parameter int C_AN_ACTIVE_LOW  = 1,
  parameter int C_SLV_DWIDTH     = 32
) (
  input  logic                      SPLB_Clk,
  input  logic                      SPLB_Rst,
  input  logic [0:C_SLV_DWIDTH-1]   Bus2IP_Data,
  input  logic [0:C_SLV_DWIDTH/8-1] Bus2IP_BE,
  input  logic [0:3]                Bus2IP_WrCE,
  input  logic [0:3]                Bus2IP_RdCE,
  output logic [0:C_SLV_DWIDTH-1]   IP2Bus_Data,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_Error,
  output logic [0:7]                segments,
  output logic [0:C_NUM_DIGITS-1]   anodes
);

  localparam int              PW         = $clog2(C_REFRESH_DIV);
  localparam logic [PW-1:0]   PRE_LAST   = PW'(C_REFRESH_DIV - 1);
  localparam int              BW         = $clog2(C_BLINK_SCANS) + 1;
  localparam logic [BW-1:0]   BLINK_LAST = BW'(C_BLINK_SCANS - 1);
  localparam logic [2:0]      IDX_LAST   = 3'(C_NUM_DIGITS - 1);
  localparam logic [7:0]      DIG_MASK   = 8'((16'd1 << C_NUM_DIGITS) - 16'd1);
  localparam logic [31:0]     DIGITS_WMASK = 32'((64'd1 << (4 * C_NUM_DIGITS)) - 64'd1);
  localparam logic [31:0]     MASK_WMASK = {8'h00, DIG_MASK, DIG_MASK, DIG_MASK};

  // Bus bit 31 is numeric bit 0; plain assignment already maps MSB to MSB.
  logic [31:0] wdata, rdata;
  logic [3:0]  be;
  logic [31:0] digitsReg, ctrlReg, maskReg, statusVal;

  logic [PW-1:0] prescaler;
  logic [2:0]    digitIdx;
  logic [3:0]    pwmCnt;
  logic [BW-1:0] blinkCnt;
  logic          blinkPhase;

  logic       enable, gapEn, slotTick, scanDone;
  logic [3:0] bright;

  assign wdata = Bus2IP_Data;
  assign be    = Bus2IP_BE;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] ben, input logic [31:0] wmask);
    logic [31:0] r;
    r = old;
    for (int j = 0; j < 4; j++)
      if (ben[j]) r[8*j +: 8] = nw[8*j +: 8] & wmask[8*j +: 8];
    return r;
  endfunction

  always_ff @(posedge SPLB_Clk) begin
    if (SPLB_Rst) begin
      digitsReg <= '0;
      ctrlReg   <= '0;
      maskReg   <= '0;
    end else begin
      if (Bus2IP_WrCE[REG_DIGITS]) digitsReg <= merge(digitsReg, wdata, be, DIGITS_WMASK);
      if (Bus2IP_WrCE[REG_CTRL])   ctrlReg   <= merge(ctrlReg, wdata, be, CTRL_WMASK);
      if (Bus2IP_WrCE[REG_MASK])   maskReg   <= merge(maskReg, wdata, be, MASK_WMASK);
    end
  end

  assign enable = ctrlReg[CTRL_EN];
  assign gapEn  = ctrlReg[CTRL_GAP];
  assign bright = ctrlReg[CTRL_BRIGHT_LSB +: 4];

  assign slotTick = enable && (prescaler == PRE_LAST);
  assign scanDone = slotTick && (digitIdx == IDX_LAST);

  // Blink phase survives a disable so blinking digits resume in step.
  always_ff @(posedge SPLB_Clk) begin
    if (SPLB_Rst || !enable) begin
      prescaler <= '0;
      digitIdx  <= '0;
      pwmCnt    <= '0;
      blinkCnt  <= '0;
      if (SPLB_Rst) blinkPhase <= 1'b0;
    end else begin
      prescaler <= slotTick ? '0 : prescaler + PW'(1);
      pwmCnt    <= pwmCnt + 4'd1;
      if (slotTick) digitIdx <= (digitIdx == IDX_LAST) ? 3'd0 : digitIdx + 3'd1;
      if (scanDone) begin
        if (blinkCnt == BLINK_LAST) begin
          blinkCnt   <= '0;
          blinkPhase <= ~blinkPhase;
        end else begin
          blinkCnt <= blinkCnt + BW'(1);
        end
      end
    end
  end

  assign statusVal = {28'd0, blinkPhase, digitIdx};

  always_comb begin
    rdata = '0;
    if (Bus2IP_RdCE[REG_DIGITS])      rdata = digitsReg;
    else if (Bus2IP_RdCE[REG_CTRL])   rdata = ctrlReg;
    else if (Bus2IP_RdCE[REG_MASK])   rdata = maskReg;
    else if (Bus2IP_RdCE[REG_STATUS]) rdata = statusVal;
  end

  assign IP2Bus_Data  = rdata;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_Error = 1'b0;

  logic [3:0]              curHex;
  logic [6:0]              glyph;
  logic                    lit, inGap;
  logic [7:0]              segOn, segD;
  logic [C_NUM_DIGITS-1:0] anOn, anD;

  seg_hex_decoder uDec (.hex(curHex), .seg(glyph));

  // Segments keep the glyph while the anode is suppressed so only the anode toggles.
  always_comb begin
    curHex = digitsReg[4*digitIdx +: 4];
    inGap  = gapEn && (prescaler < PW'(2));
    lit    = enable && !maskReg[MASK_BLANK_LSB + int'(digitIdx)]
             && !(maskReg[MASK_BLINK_LSB + int'(digitIdx)] && blinkPhase)
             && (pwmCnt <= bright) && !inGap;
    for (int k = 0; k < C_NUM_DIGITS; k++) anOn[k] = lit && (digitIdx == 3'(k));
    segOn = enable ? {maskReg[MASK_DP_LSB + int'(digitIdx)], glyph} : 8'h00;
    if (SPLB_Rst) begin
      anOn  = '0;
      segOn = 8'h00;
    end
    segD = apply_polarity(segOn, C_SEG_ACTIVE_LOW != 0);
    anD  = anOn ^ {C_NUM_DIGITS{C_AN_ACTIVE_LOW != 0}};
  end

  always_ff @(posedge SPLB_Clk) begin
    for (int i = 0; i < 8; i++) segments[i] <= segD[i];
    for (int k = 0; k < C_NUM_DIGITS; k++) anodes[k] <= anD[k];
  end

endmodule
